// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase/fault codes and phase-step helpers for the traffic light monitor.
// Pure declarations; no latency or backpressure of its own.
package traffic_pkg;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam int         RED_BIT     = 2;

   localparam logic [4:0] DWELL_MAX   = 5'd31;

   typedef enum logic [2:0] {
      PH_ALL_RED   = 3'd0,
      PH_NS_GREEN  = 3'd1,
      PH_NS_YELLOW = 3'd2,
      PH_EW_GREEN  = 3'd3,
      PH_EW_YELLOW = 3'd4,
      PH_INVALID   = 3'd7
   } phase_t;

   typedef enum logic [2:0] {
      FC_NONE         = 3'd0,
      FC_ENCODING     = 3'd1,
      FC_CONFLICT     = 3'd2,
      FC_SEQUENCE     = 3'd3,
      FC_YELLOW_SHORT = 3'd4,
      FC_GREEN_LONG   = 3'd5,
      FC_ALLRED_SHORT = 3'd6,
      FC_STUCK_ALLRED = 3'd7
   } fault_t;

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_MONITOR = 2'd1,
      ST_FAULT   = 2'd2
   } mon_state_t;

   typedef enum logic [1:0] {
      LAST_NONE = 2'd0,
      LAST_NS   = 2'd1,
      LAST_EW   = 2'd2
   } last_yellow_t;

   function automatic logic lamp_onehot(input logic [2:0] lamp);
      return (lamp == LAMP_RED) || (lamp == LAMP_YELLOW) || (lamp == LAMP_GREEN);
   endfunction

   function automatic logic is_green(input phase_t ph);
      return (ph == PH_NS_GREEN) || (ph == PH_EW_GREEN);
   endfunction

   function automatic logic is_yellow(input phase_t ph);
      return (ph == PH_NS_YELLOW) || (ph == PH_EW_YELLOW);
   endfunction

   // Each approach may only run GREEN -> YELLOW -> ALL_RED -> GREEN.
   function automatic logic legal_step(input phase_t cur_ph, input phase_t new_ph);
      logic ok;
      case (cur_ph)
         PH_NS_GREEN:  ok = (new_ph == PH_NS_YELLOW);
         PH_NS_YELLOW: ok = (new_ph == PH_ALL_RED);
         PH_EW_GREEN:  ok = (new_ph == PH_EW_YELLOW);
         PH_EW_YELLOW: ok = (new_ph == PH_ALL_RED);
         PH_ALL_RED:   ok = is_green(new_ph);
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp observation inputs and monitor status outputs bundled for the traffic light monitor.
// Wires only; no latency, no backpressure.
interface traffic_light_monitor_if;
   import traffic_pkg::*;

   logic [2:0] NS_light;
   logic [2:0] EW_light;
   logic       clear_fault;
   phase_t     phase;
   logic       fault;
   fault_t     fault_code;
   logic       flash_req;
   logic [7:0] cycle_count;

   modport master (
      output NS_light, EW_light, clear_fault,
      input  phase, fault, fault_code, flash_req, cycle_count
   );

   modport slave (
      input  NS_light, EW_light, clear_fault,
      output phase, fault, fault_code, flash_req, cycle_count
   );

endinterface

// File: rtl/traffic_phase_decoder.sv
// Combinational map of the two lamp triples to a phase code plus one-hot and conflict flags.
// Zero latency; no backpressure.
module traffic_phase_decoder
   import traffic_pkg::*;
(
   input  logic [2:0] NS_light,
   input  logic [2:0] EW_light,
   output phase_t     phase,
   output logic       onehot_ok,
   output logic       conflict
);

   always_comb begin
      onehot_ok = lamp_onehot(NS_light) && lamp_onehot(EW_light);
      // A dark or non-red approach counts as "not stopped" for the conflict check.
      conflict  = !NS_light[RED_BIT] && !EW_light[RED_BIT];
      phase     = PH_INVALID;
      if (onehot_ok && !conflict) begin
         if (NS_light == LAMP_RED && EW_light == LAMP_RED)
            phase = PH_ALL_RED;
         else if (NS_light == LAMP_GREEN)
            phase = PH_NS_GREEN;
         else if (NS_light == LAMP_YELLOW)
            phase = PH_NS_YELLOW;
         else if (EW_light == LAMP_GREEN)
            phase = PH_EW_GREEN;
         else
            phase = PH_EW_YELLOW;
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches both approaches, checks sequence/alternation/timing, latches the first fault, counts cycles.
// Every output registered one clk edge after the sampled lamps; no backpressure, samples every cycle.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_YELLOW = 2,
   parameter int MAX_GREEN  = 15,
   parameter int MIN_ALLRED = 1,
   parameter int MAX_ALLRED = 15
)(
   input  logic                   clk,
   input  logic                   rst,
   traffic_light_monitor_if.slave mon
);

   localparam logic [5:0] MIN_YELLOW_W = 6'(MIN_YELLOW);
   localparam logic [5:0] MAX_GREEN_W  = 6'(MAX_GREEN);
   localparam logic [5:0] MIN_ALLRED_W = 6'(MIN_ALLRED);
   localparam logic [5:0] MAX_ALLRED_W = 6'(MAX_ALLRED);

   mon_state_t   state_q, state_d;
   phase_t       phase_q, dec_phase;
   logic         onehot_ok, conflict;
   logic [4:0]   dwell_q, dwell_d;
   logic [5:0]   dwell_next;
   last_yellow_t last_q, last_d;
   logic         fault_q, fault_d;
   fault_t       code_q, code_d, mon_code;
   logic [7:0]   cnt_q, cnt_d;
   logic         changed;

   traffic_phase_decoder u_dec (
      .NS_light  (mon.NS_light),
      .EW_light  (mon.EW_light),
      .phase     (dec_phase),
      .onehot_ok (onehot_ok),
      .conflict  (conflict)
   );

   assign changed    = (dec_phase != phase_q);
   assign dwell_next = {1'b0, dwell_q} + 6'd1;

   // Lowest fault code wins when several checks trip on the same sample.
   always_comb begin
      mon_code = FC_NONE;
      if (!onehot_ok)
         mon_code = FC_ENCODING;
      else if (conflict)
         mon_code = FC_CONFLICT;
      else if (changed && !legal_step(phase_q, dec_phase))
         mon_code = FC_SEQUENCE;
      else if (changed && phase_q == PH_ALL_RED &&
               ((dec_phase == PH_NS_GREEN && last_q == LAST_NS) ||
                (dec_phase == PH_EW_GREEN && last_q == LAST_EW)))
         mon_code = FC_SEQUENCE;
      else if (changed && is_yellow(phase_q) && {1'b0, dwell_q} < MIN_YELLOW_W)
         mon_code = FC_YELLOW_SHORT;
      else if (!changed && is_green(dec_phase) && dwell_next > MAX_GREEN_W)
         mon_code = FC_GREEN_LONG;
      else if (changed && phase_q == PH_ALL_RED && {1'b0, dwell_q} < MIN_ALLRED_W)
         mon_code = FC_ALLRED_SHORT;
      else if (!changed && dec_phase == PH_ALL_RED && dwell_next > MAX_ALLRED_W)
         mon_code = FC_STUCK_ALLRED;
   end

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      last_d  = last_q;
      fault_d = fault_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STARTUP: begin
            if (conflict) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               code_d  = FC_CONFLICT;
            end else if (dec_phase == PH_ALL_RED) begin
               state_d = ST_MONITOR;
               dwell_d = 5'd1;
            end
         end
         ST_MONITOR: begin
            if (changed)
               dwell_d = 5'd1;
            else if (dwell_q != DWELL_MAX)
               dwell_d = dwell_q + 5'd1;
            if (changed && dec_phase == PH_ALL_RED) begin
               if (phase_q == PH_NS_YELLOW)
                  last_d = LAST_NS;
               if (phase_q == PH_EW_YELLOW) begin
                  last_d = LAST_EW;
                  cnt_d  = cnt_q + 8'd1;
               end
            end
            if (mon_code != FC_NONE) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               code_d  = mon_code;
            end
         end
         ST_FAULT: begin
            // Only release into a safe all-red picture.
            if (mon.clear_fault && dec_phase == PH_ALL_RED) begin
               state_d = ST_STARTUP;
               fault_d = 1'b0;
               code_d  = FC_NONE;
               dwell_d = 5'd0;
               last_d  = LAST_NONE;
            end
         end
         default: state_d = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_STARTUP;
         phase_q <= PH_ALL_RED;
         dwell_q <= 5'd0;
         last_q  <= LAST_NONE;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         phase_q <= dec_phase;
         dwell_q <= dwell_d;
         last_q  <= last_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mon.phase       = phase_q;
   assign mon.fault       = fault_q;
   assign mon.fault_code  = code_q;
   assign mon.flash_req   = fault_q;
   assign mon.cycle_count = cnt_q;

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 2: minimum consecutive yellow samples per approach.
REQ-002 Parameter MAX_GREEN, default 15: maximum consecutive green samples per approach.
REQ-003 Parameter MIN_ALLRED, default 1: minimum all-red samples before any green.
REQ-004 Parameter MAX_ALLRED, default 15: all-red samples beyond which the light is stuck.
REQ-005 clk  in  1  clock; one clk cycle is one light-timing unit (1 s).
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 NS_light  in  3  observed North-South lamps, one-hot {red,yellow,green} = 100/010/001.
REQ-008 EW_light  in  3  observed East-West lamps, same encoding.
REQ-009 clear_fault  in  1  level request to leave FAULT.
REQ-010 phase  out  3  decoded phase: 0 ALL_RED, 1 NS_GREEN, 2 NS_YELLOW, 3 EW_GREEN, 4 EW_YELLOW, 7 INVALID.
REQ-011 fault  out  1  latched fault flag.
REQ-012 fault_code  out  3  first fault captured: 0 none, 1 encoding, 2 conflict, 3 sequence, 4 yellow short, 5 green long, 6 all-red short, 7 stuck all-red.
REQ-013 flash_req  out  1  fail-safe flash-red request to the cabinet; equals fault.
REQ-014 cycle_count  out  8  completed full NS+EW cycles.

Function
REQ-015 All outputs SHALL be registered and update at the clk edge that samples the light inputs; fault latency is one edge after the offending value appears.
REQ-016 Monitor FSM states SHALL be STARTUP, MONITOR, FAULT.
REQ-017 STARTUP: only the conflict check is active; first sample decoding to ALL_RED -> MONITOR with dwell=1; conflict -> FAULT code 2.
REQ-018 Dwell counter (5 bits, saturating at 31) SHALL load 1 on a phase change and increment on an unchanged phase.
REQ-019 Encoding check: either input not one-hot -> code 1; phase reports INVALID.
REQ-020 Conflict check: both approaches non-red simultaneously -> code 2.
REQ-021 Sequence check: only GREEN->YELLOW->ALL_RED->GREEN is legal per approach; any other phase transition -> code 3.
REQ-022 Alternation: the green after an NS_YELLOW SHALL be EW_GREEN and vice versa; violation -> code 3; the first green after STARTUP may be either.
REQ-023 Leaving yellow with dwell < MIN_YELLOW -> code 4.
REQ-024 Green sample that would make dwell > MAX_GREEN -> code 5.
REQ-025 ALL_RED->GREEN with all-red dwell < MIN_ALLRED -> code 6.
REQ-026 All-red sample that would make dwell > MAX_ALLRED -> code 7.
REQ-027 Simultaneous faults SHALL be prioritised encoding > conflict > sequence > timing codes 4..7; the lowest code wins.
REQ-028 Any fault in MONITOR -> FAULT, fault=1, fault_code latched; later faults SHALL NOT overwrite it.
REQ-029 FAULT -> STARTUP only when clear_fault=1 and the current sample is ALL_RED; fault, fault_code, dwell and alternation history clear on that edge; cycle_count is kept.
REQ-030 phase SHALL track the input in every state, including FAULT.
REQ-031 cycle_count SHALL increment on each EW_YELLOW->ALL_RED transition in MONITOR and wrap 255->0.

Reset
REQ-032 While rst=0: state STARTUP, phase 0, fault 0, fault_code 0, flash_req 0, cycle_count 0, dwell 0, alternation history cleared.
REQ-033 Reset asserted mid-fault or mid-cycle SHALL abandon all history without emitting a fault.

Structure
REQ-034 Shared package traffic_pkg SHALL hold the lamp encodings (red/yellow/green), the phase codes and the fault codes.
REQ-035 One combinational sub-module, traffic_phase_decoder, SHALL map (NS_light, EW_light) to phase plus the onehot_ok and conflict flags.

Verification
REQ-036 Reset, then all-red x1, NS green x10, NS yellow x2, all-red x1, EW green x10, EW yellow x2, all-red -> no fault, cycle_count=1.
REQ-037 In MONITOR, NS=001 with EW=001 -> fault=1, fault_code=2, flash_req=1 at the next edge.
REQ-038 NS=011 applied together with an illegal transition -> fault_code=1, the encoding code winning priority.
REQ-039 NS green -> NS yellow x1 -> all-red -> fault_code=4; a later conflict leaves code 4.
REQ-040 NS green held 16 samples -> fault_code=5 on the 16th; clear_fault while green -> stays FAULT; all-red with clear_fault -> STARTUP, fault=0.
REQ-041 NS cycle, all-red, then NS green again -> fault_code=3; after 255 legal cycles, one more -> cycle_count=0.
